decode_pipe_stage: RTL

DECODE_PIPE_STAGE -- requirements
Module: decode_pipe_stage

---
 rtl/decode_pipe_stage.sv | 115 +++++++++++
 1 files changed

// File: rtl/decode_pipe_stage.sv
// rtl/decode_pipe_stage.sv - decode stage: 16-entry regfile with W bypass, load-use stall, D->E register
module decode_pipe_stage #(
  parameter int DW     = 32,
  parameter int CW     = 8,
  parameter int PC_REG = 15
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          ValidD,
  input  logic [31:0]   InstrD,
  input  logic [1:0]    RegSrcD,
  input  logic          RegWriteD,
  input  logic          MemToRegD,
  input  logic [CW-1:0] CtrlD,
  input  logic [DW-1:0] ExtImmD,
  input  logic [DW-1:0] PCPlus8D,
  input  logic          RegWriteW,
  input  logic [3:0]    WA3W,
  input  logic [DW-1:0] ResultW,
  input  logic          FlushE,
  output logic          StallD,
  output logic [DW-1:0] RD1E,
  output logic [DW-1:0] RD2E,
  output logic [DW-1:0] ExtImmE,
  output logic [3:0]    RA1E,
  output logic [3:0]    RA2E,
  output logic [3:0]    WA3E,
  output logic          ValidE,
  output logic          RegWriteE,
  output logic          MemToRegE,
  output logic [CW-1:0] CtrlE,
  output logic [15:0]   StallCnt
);

  localparam logic [3:0] PC_IDX = 4'(PC_REG);

  logic [DW-1:0] regs [16];
  logic [3:0]    ra1_d;
  logic [3:0]    ra2_d;
  logic [DW-1:0] rd1_d;
  logic [DW-1:0] rd2_d;
  logic          load_use;
  logic          unused_instr;

  assign unused_instr = ^{InstrD[31:20], InstrD[11:4]};

  assign ra1_d = RegSrcD[0] ? PC_IDX : InstrD[19:16];
  assign ra2_d = RegSrcD[1] ? InstrD[15:12] : InstrD[3:0];

  // PC index wins over the write-through bypass, so a W write to PC never shows up here
  assign rd1_d = (ra1_d == PC_IDX)                ? PCPlus8D :
                 (RegWriteW && (WA3W == ra1_d))   ? ResultW  : regs[ra1_d];
  assign rd2_d = (ra2_d == PC_IDX)                ? PCPlus8D :
                 (RegWriteW && (WA3W == ra2_d))   ? ResultW  : regs[ra2_d];

  assign load_use = ValidD && ValidE && MemToRegE && RegWriteE &&
                    ((WA3E == ra1_d) || (WA3E == ra2_d)) && (WA3E != PC_IDX);

  assign StallD = load_use && !FlushE;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      for (int i = 0; i < 16; i++) regs[i] <= '0;
    end else if (RegWriteW && (WA3W != PC_IDX)) begin
      regs[WA3W] <= ResultW;
    end
  end

  // Flush and load-use both produce the same bubble, so they share one branch
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      ValidE    <= 1'b0;
      RegWriteE <= 1'b0;
      MemToRegE <= 1'b0;
      CtrlE     <= '0;
      RD1E      <= '0;
      RD2E      <= '0;
      ExtImmE   <= '0;
      RA1E      <= '0;
      RA2E      <= '0;
      WA3E      <= '0;
    end else if (FlushE || load_use) begin
      ValidE    <= 1'b0;
      RegWriteE <= 1'b0;
      MemToRegE <= 1'b0;
      CtrlE     <= '0;
      RD1E      <= '0;
      RD2E      <= '0;
      ExtImmE   <= '0;
      RA1E      <= '0;
      RA2E      <= '0;
      WA3E      <= '0;
    end else begin
      ValidE    <= ValidD;
      RegWriteE <= RegWriteD && ValidD;
      MemToRegE <= MemToRegD && ValidD;
      CtrlE     <= CtrlD;
      RD1E      <= rd1_d;
      RD2E      <= rd2_d;
      ExtImmE   <= ExtImmD;
      RA1E      <= ra1_d;
      RA2E      <= ra2_d;
      WA3E      <= InstrD[15:12];
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      StallCnt <= '0;
    end else if (StallD && (StallCnt != 16'hFFFF)) begin
      StallCnt <= StallCnt + 16'd1;
    end
  end

endmodule
